// File: rtl/display_scanner_if.sv
// rtl/display_scanner_if.sv - converter-side inputs and pin-side outputs of the 4-digit scanner
interface display_scanner_if;
  logic       en;
  logic       load;
  logic [6:0] d0;
  logic [6:0] d1;
  logic [6:0] d2;
  logic [6:0] d3;
  logic [3:0] dp_in;
  logic       blank_lz;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;

  modport master (
    output en, load, d0, d1, d2, d3, dp_in, blank_lz,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  en, load, d0, d1, d2, d3, dp_in, blank_lz,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - double-buffered time-multiplexed driver for a 4-digit common-anode display
// with leading-zero blanking and a dark guard at the start of every digit slot.
module display_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4
) (
  input logic              clk,
  input logic              reset,
  display_scanner_if.slave io_bus
);
  localparam int              DW        = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0]   DIV_LAST  = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0]   GUARD_LEN = DW'(GUARD);
  localparam logic [6:0]      SEG_OFF   = 7'b1111111;
  localparam logic [6:0]      SEG_ZERO  = 7'b0000001;

  logic [DW-1:0]   r_div_cnt;
  logic [1:0]      r_idx;
  logic            r_pend_valid;
  logic [3:0][6:0] r_pend_d;
  logic [3:0]      r_pend_dp;
  logic [3:0][6:0] r_act_d;
  logic [3:0]      r_act_dp;
  logic            r_wrap;
  logic [6:0]      r_seg;
  logic            r_dp;
  logic [3:0]      r_an;
  logic            r_frame_tick;

  logic [3:0][6:0] w_in_d;
  logic            w_boundary;
  logic            w_commit;
  logic [3:0]      w_lz_blank;
  logic            w_blank;

  assign w_in_d     = {io_bus.d3, io_bus.d2, io_bus.d1, io_bus.d0};
  assign w_boundary = (r_idx == 2'd3) && (r_div_cnt == DIV_LAST);
  assign w_commit   = !io_bus.en || w_boundary;

  // Blanking ripples rightwards from digit 3; any set dp or nonzero digit ends the run.
  always_comb begin
    w_lz_blank    = '0;
    w_lz_blank[3] = io_bus.blank_lz && (r_act_d[3] == SEG_ZERO) && !r_act_dp[3];
    w_lz_blank[2] = w_lz_blank[3] && (r_act_d[2] == SEG_ZERO) && !r_act_dp[2];
    w_lz_blank[1] = w_lz_blank[2] && (r_act_d[1] == SEG_ZERO) && !r_act_dp[1];
    w_blank       = !io_bus.en || (r_div_cnt < GUARD_LEN) || w_lz_blank[r_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt    <= '0;
      r_idx        <= 2'd0;
      r_pend_valid <= 1'b0;
      r_pend_d     <= {4{SEG_OFF}};
      r_pend_dp    <= 4'b0000;
      r_act_d      <= {4{SEG_OFF}};
      r_act_dp     <= 4'b0000;
      r_wrap       <= 1'b0;
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_an         <= 4'b1111;
      r_frame_tick <= 1'b0;
    end else begin
      if (io_bus.load) begin
        r_pend_d  <= w_in_d;
        r_pend_dp <= io_bus.dp_in;
      end

      // A load coinciding with a commit bypasses the pending buffer.
      if (w_commit) begin
        r_pend_valid <= 1'b0;
        if (io_bus.load) begin
          r_act_d  <= w_in_d;
          r_act_dp <= io_bus.dp_in;
        end else if (r_pend_valid) begin
          r_act_d  <= r_pend_d;
          r_act_dp <= r_pend_dp;
        end
      end else if (io_bus.load) begin
        r_pend_valid <= 1'b1;
      end

      if (!io_bus.en) begin
        r_div_cnt <= '0;
        r_idx     <= 2'd0;
      end else if (r_div_cnt == DIV_LAST) begin
        r_div_cnt <= '0;
        r_idx     <= r_idx + 2'd1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      // Delayed one cycle so the tick lines up with the first registered output of slot 0.
      r_wrap       <= io_bus.en && w_boundary;
      r_frame_tick <= io_bus.en && r_wrap;

      if (w_blank) begin
        r_seg <= SEG_OFF;
        r_dp  <= 1'b1;
        r_an  <= 4'b1111;
      end else begin
        r_seg <= r_act_d[r_idx];
        r_dp  <= ~r_act_dp[r_idx];
        r_an  <= ~(4'b0001 << r_idx);
      end
    end
  end

  assign io_bus.seg        = r_seg;
  assign io_bus.dp         = r_dp;
  assign io_bus.an         = r_an;
  assign io_bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - scoreboard bench for display_scanner against a slot/phase reference model
module tb_display_scanner;
  localparam int         RD   = 8;
  localparam int         GD   = 2;
  localparam int         FR   = 4 * RD;
  localparam logic [6:0] OFF  = 7'b1111111;
  localparam logic [6:0] ZERO = 7'b0000001;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  display_scanner_if bus ();

  display_scanner #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Model: m_t = consecutive enabled cycles before the current one.
  int         m_t;
  logic [6:0] m_act  [4];
  logic [6:0] m_pend [4];
  logic [3:0] m_act_dp;
  logic [3:0] m_pend_dp;
  bit         m_pend_valid;

  function automatic logic [6:0] pat(input int n);
    case (n)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    m_t = 0;
    for (int i = 0; i < 4; i++) begin
      m_act[i]  = OFF;
      m_pend[i] = OFF;
    end
    m_act_dp     = 4'b0000;
    m_pend_dp    = 4'b0000;
    m_pend_valid = 0;
  endtask

  task automatic drive(input logic en, input logic load, input logic [6:0] d3, input logic [6:0] d2,
                       input logic [6:0] d1, input logic [6:0] d0, input logic [3:0] dpv, input logic lz);
    exp_t       e;
    int         slot;
    int         phase;
    logic [6:0] din [4];
    bit         keep;
    logic [3:0] lzb;
    @(negedge clk);
    bus.en       = en;
    bus.load     = load;
    bus.d3       = d3;
    bus.d2       = d2;
    bus.d1       = d1;
    bus.d0       = d0;
    bus.dp_in    = dpv;
    bus.blank_lz = lz;
    din[0] = d0; din[1] = d1; din[2] = d2; din[3] = d3;
    slot  = (m_t / RD) % 4;
    phase = m_t % RD;
    keep  = 0;
    for (int i = 3; i >= 0; i--) begin
      if (i == 0 || m_act_dp[i] || m_act[i] != ZERO) keep = 1;
      lzb[i] = lz && !keep;
    end
    e.seg = OFF;
    e.dp  = 1'b1;
    e.an  = 4'hf;
    if (en && phase >= GD && !lzb[slot]) begin
      e.an[slot] = 1'b0;
      e.seg      = m_act[slot];
      e.dp       = !m_act_dp[slot];
    end
    e.tick = en && (m_t > 0) && (m_t % FR == 0);
    exp_q.push_back(e);
    last_exp = e;
    if (load) begin
      for (int i = 0; i < 4; i++) m_pend[i] = din[i];
      m_pend_dp = dpv;
    end
    if (!en || (m_t % FR == FR - 1)) begin
      if (load) begin
        for (int i = 0; i < 4; i++) m_act[i] = din[i];
        m_act_dp = dpv;
      end else if (m_pend_valid) begin
        for (int i = 0; i < 4; i++) m_act[i] = m_pend[i];
        m_act_dp = m_pend_dp;
      end
      m_pend_valid = 0;
    end else if (load) begin
      m_pend_valid = 1;
    end
    m_t = en ? m_t + 1 : 0;
  endtask

  task automatic idle(input int n, input logic en, input logic lz);
    repeat (n) drive(en, 1'b0, OFF, OFF, OFF, OFF, 4'h0, lz);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      total++;
      if ({bus.seg, bus.dp, bus.an, bus.frame_tick} !== mon_e) begin
        bad++;
        $display("FAIL scoreboard @%0t: seg=%b dp=%b an=%b tick=%b expected seg=%b dp=%b an=%b tick=%b",
                 $time, bus.seg, bus.dp, bus.an, bus.frame_tick, mon_e.seg, mon_e.dp, mon_e.an, mon_e.tick);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   found;
    logic en_r;
    logic lz_r;
    bus.en = 1'b0; bus.load = 1'b0; bus.blank_lz = 1'b0; bus.dp_in = 4'h0;
    bus.d0 = OFF; bus.d1 = OFF; bus.d2 = OFF; bus.d3 = OFF;
    #2 reset = 1'b1;
    #1;
    check("reset_seg",  {25'd0, bus.seg}, {25'd0, OFF});
    check("reset_dp",   {31'd0, bus.dp}, 32'd1);
    check("reset_an",   {28'd0, bus.an}, 32'hf);
    check("reset_tick", {31'd0, bus.frame_tick}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();

    // Blank scan across more than two frames.
    idle(70, 1'b1, 1'b0);

    // Mid-frame load of 4,3,2,1.
    for (int k = 0; k < FR && (m_t % FR) != 10; k++) idle(1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, pat(4), pat(3), pat(2), pat(1), 4'h0, 1'b0);
    idle(60, 1'b1, 1'b0);

    // Leading zeros, then a dp on digit 2 stops the blanking.
    drive(1'b1, 1'b1, ZERO, ZERO, pat(2), pat(7), 4'h0, 1'b1);
    idle(70, 1'b1, 1'b1);
    drive(1'b1, 1'b1, ZERO, ZERO, pat(2), pat(7), 4'b0100, 1'b1);
    idle(70, 1'b1, 1'b1);

    // Load on the frame boundary, then a later load that must wait.
    found = 0;
    for (int k = 0; k < FR && !found; k++) begin
      if ((m_t % FR) == FR - 1) found = 1;
      else idle(1, 1'b1, 1'b0);
    end
    drive(1'b1, 1'b1, pat(9), pat(8), pat(6), pat(5), 4'b0001, 1'b0);
    idle(10, 1'b1, 1'b0);
    drive(1'b1, 1'b1, pat(1), pat(2), pat(3), pat(0), 4'b1000, 1'b0);
    idle(60, 1'b1, 1'b0);

    // Disable mid-slot, load while disabled, re-enable.
    for (int k = 0; k < RD && (m_t % RD) != 5; k++) idle(1, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, pat(3), pat(5), pat(7), pat(8), 4'h0, 1'b0);
    idle(1, 1'b0, 1'b0);
    idle(40, 1'b1, 1'b0);

    // Randomized traffic.
    en_r = 1'b1;
    lz_r = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      logic [6:0] rd [4];
      logic [3:0] rdp;
      if ($urandom_range(0, 59) == 0) en_r = !en_r;
      if ($urandom_range(0, 199) == 0) lz_r = !lz_r;
      for (int i = 0; i < 4; i++) rd[i] = ($urandom_range(0, 9) < 4) ? ZERO : pat($urandom_range(0, 9));
      rdp = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      drive(en_r, ($urandom_range(0, 11) == 0), rd[3], rd[2], rd[1], rd[0], rdp, lz_r);
    end

    // Asynchronous reset during a lit slot.
    drive(1'b1, 1'b1, pat(4), pat(3), pat(2), pat(1), 4'h0, 1'b0);
    idle(2 * FR, 1'b1, 1'b0);
    found = 0;
    for (int k = 0; k < 64 && !found; k++) begin
      drive(1'b1, 1'b0, OFF, OFF, OFF, OFF, 4'h0, 1'b0);
      @(posedge clk);
      #2;
      if (last_exp.an != 4'hf) found = 1;
    end
    check("lit_slot_found", {31'd0, found}, 32'd1);
    check("pre_reset_an", {28'd0, bus.an}, {28'd0, last_exp.an});
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_reset_seg", {25'd0, bus.seg}, {25'd0, OFF});
    check("async_reset_an",  {28'd0, bus.an}, 32'hf);
    check("async_reset_dp",  {31'd0, bus.dp}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    idle(80, 1'b1, 1'b0);

    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
